// File: rtl/ex_stage_md.sv
// ex_stage_md: RV32 execute stage with single-cycle ALU path, N-source operand
// forwarding and an iterative RV32M multiply/divide unit with stall/flush.
// Optional feature macro: EX_FAST_MUL_EN (single-cycle multiplier for MUL*).
// ALU control decode and ALU are the pipeline's standard ones, kept as local
// functions so the stage is one self-contained unit.
module ex_stage_md #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [DWIDTH-1:0]                    data_rs1,
    input  logic [DWIDTH-1:0]                    data_rs2,
    input  logic [DWIDTH-1:0]                    data_pc,
    input  logic [DWIDTH-1:0]                    data_imm,
    input  logic [NUM_FWD*DWIDTH-1:0]            fwd_data,
    input  logic [$clog2(NUM_FWD+1)-1:0]         fwd_a_sel,
    input  logic [$clog2(NUM_FWD+1)-1:0]         fwd_b_sel,
    input  logic [3:0]                           ctrl_alu_func,
    input  logic [1:0]                           ctrl_alu_op,
    input  logic [1:0]                           ctrl_alu_src_a,
    input  logic [1:0]                           ctrl_alu_src_b,
    input  logic                                 ctrl_md_en,
    input  logic [2:0]                           md_func,
    input  logic                                 flush,
    output logic                                 stall,
    output logic                                 out_valid,
    output logic [DWIDTH-1:0]                    result
);

    localparam int unsigned SELW = $clog2(NUM_FWD + 1);
    localparam int unsigned CW   = $clog2(DWIDTH);
    localparam int unsigned SHW  = $clog2(DWIDTH);
    localparam int unsigned PW   = 2 * DWIDTH;

    localparam logic [3:0] AC_ADD  = 4'd0;
    localparam logic [3:0] AC_SUB  = 4'd1;
    localparam logic [3:0] AC_SLL  = 4'd2;
    localparam logic [3:0] AC_SLT  = 4'd3;
    localparam logic [3:0] AC_SLTU = 4'd4;
    localparam logic [3:0] AC_XOR  = 4'd5;
    localparam logic [3:0] AC_SRL  = 4'd6;
    localparam logic [3:0] AC_SRA  = 4'd7;
    localparam logic [3:0] AC_OR   = 4'd8;
    localparam logic [3:0] AC_AND  = 4'd9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // ALU control: op 00 add (ld/st), 01 sub (branch), 10 R-type, 11 I-type.
    // func = {funct7[5], funct3}; funct7[5] only selects SUB on R-type.
    function automatic logic [3:0] alu_ctrl_dec(input logic [1:0] op, input logic [3:0] func);
        logic [3:0] c;
        c = AC_ADD;
        case (op)
            2'b00: c = AC_ADD;
            2'b01: c = AC_SUB;
            default: begin
                case (func[2:0])
                    3'b000:  c = (op == 2'b10 && func[3]) ? AC_SUB : AC_ADD;
                    3'b001:  c = AC_SLL;
                    3'b010:  c = AC_SLT;
                    3'b011:  c = AC_SLTU;
                    3'b100:  c = AC_XOR;
                    3'b101:  c = func[3] ? AC_SRA : AC_SRL;
                    3'b110:  c = AC_OR;
                    default: c = AC_AND;
                endcase
            end
        endcase
        return c;
    endfunction

    // Single-cycle ALU.
    function automatic logic [DWIDTH-1:0] alu_exec(input logic [DWIDTH-1:0] a,
                                                   input logic [DWIDTH-1:0] b,
                                                   input logic [3:0] c);
        logic [DWIDTH-1:0] y;
        logic [SHW-1:0]    sh;
        sh = b[SHW-1:0];
        case (c)
            AC_ADD:  y = a + b;
            AC_SUB:  y = a - b;
            AC_SLL:  y = a << sh;
            AC_SLT:  y = DWIDTH'($signed(a) < $signed(b));
            AC_SLTU: y = DWIDTH'(a < b);
            AC_XOR:  y = a ^ b;
            AC_SRL:  y = a >> sh;
            AC_SRA:  y = $unsigned($signed(a) >>> sh);
            AC_OR:   y = a | b;
            AC_AND:  y = a & b;
            default: y = '0;
        endcase
        return y;
    endfunction

    // Final mul/div result from magnitude product or {remainder, quotient}.
    function automatic logic [DWIDTH-1:0] md_fix(input logic [2:0] func,
                                                 input logic [PW-1:0] prod,
                                                 input logic neg_q,
                                                 input logic neg_r,
                                                 input logic dz,
                                                 input logic [DWIDTH-1:0] dvd);
        logic [PW-1:0]     full;
        logic [DWIDTH-1:0] q;
        logic [DWIDTH-1:0] r;
        logic [DWIDTH-1:0] y;
        full = neg_q ? -prod : prod;
        q    = prod[DWIDTH-1:0];
        r    = prod[PW-1:DWIDTH];
        if (!func[2])
            y = (func[1:0] == 2'b00) ? full[DWIDTH-1:0] : full[PW-1:DWIDTH];
        else if (!func[1])
            y = dz ? '1 : (neg_q ? -q : q);
        else
            y = dz ? dvd : (neg_r ? -r : r);
        return y;
    endfunction

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          func_q;
    logic                neg_q_q;
    logic                neg_r_q;
    logic                dz_q;
    logic [DWIDTH-1:0]   dvd_q;
    logic [DWIDTH-1:0]   opnd_q;
    logic [PW-1:0]       prod_q;
    logic [DWIDTH-1:0]   res_q;

    logic [DWIDTH-1:0]   op_a;
    logic [DWIDTH-1:0]   op_b;
    logic [DWIDTH-1:0]   alu_a;
    logic [DWIDTH-1:0]   alu_b;
    logic [DWIDTH-1:0]   alu_result;

    // Forwarding: select register file value or one of the forwarding slots.
    always_comb begin
        op_a = data_rs1;
        op_b = data_rs2;
        for (int k = 1; k <= int'(NUM_FWD); k++) begin
            if (fwd_a_sel == SELW'(k)) op_a = fwd_data[(k-1)*DWIDTH +: DWIDTH];
            if (fwd_b_sel == SELW'(k)) op_b = fwd_data[(k-1)*DWIDTH +: DWIDTH];
        end
    end

    // ALU source muxes, applied after forwarding.
    always_comb begin
        case (ctrl_alu_src_a)
            2'b01:   alu_a = data_pc;
            2'b10:   alu_a = '0;
            default: alu_a = op_a;
        endcase
        case (ctrl_alu_src_b)
            2'b01:   alu_b = data_imm;
            2'b10:   alu_b = DWIDTH'(4);
            default: alu_b = op_b;
        endcase
    end

    assign alu_result = alu_exec(alu_a, alu_b, alu_ctrl_dec(ctrl_alu_op, ctrl_alu_func));

    // Operand sign handling at acceptance: magnitudes plus result sign flags.
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic [DWIDTH-1:0] mag_a;
    logic [DWIDTH-1:0] mag_b;
    always_comb begin
        is_div = md_func[2];
        a_neg  = op_a[DWIDTH-1] & (is_div ? ~md_func[0] : (md_func[1:0] != 2'b11));
        b_neg  = op_b[DWIDTH-1] & (is_div ? ~md_func[0] : ~md_func[1]);
        mag_a  = a_neg ? -op_a : op_a;
        mag_b  = b_neg ? -op_b : op_b;
    end

    // One iteration: shift-add multiply or restoring divide step.
    logic [DWIDTH:0]   mul_sum;
    logic [DWIDTH:0]   div_shift;
    logic [DWIDTH:0]   div_diff;
    logic [PW-1:0]     step_next;
    always_comb begin
        mul_sum   = {1'b0, prod_q[PW-1:DWIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod_q[PW-1:DWIDTH], prod_q[DWIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!func_q[2])
            step_next = {mul_sum, prod_q[DWIDTH-1:1]};
        else if (div_diff[DWIDTH])
            step_next = {div_shift[DWIDTH-1:0], prod_q[DWIDTH-2:0], 1'b0};
        else
            step_next = {div_diff[DWIDTH-1:0], prod_q[DWIDTH-2:0], 1'b1};
    end

`ifdef EX_FAST_MUL_EN
    logic [PW-1:0] fast_prod;
    assign fast_prod = PW'(mag_a) * PW'(mag_b);
`endif

    // Mul/div FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            func_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && ctrl_md_en) begin
                        func_q  <= md_func;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= (op_b == '0);
                        dvd_q   <= op_a;
                        opnd_q  <= is_div ? mag_b : mag_a;
                        prod_q  <= {{DWIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        cnt     <= CW'(DWIDTH - 1);
`ifdef EX_FAST_MUL_EN
                        if (!is_div) begin
                            res_q <= md_fix(md_func, fast_prod, a_neg ^ b_neg, a_neg,
                                            (op_b == '0), op_a);
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    prod_q <= step_next;
                    if (cnt == '0) begin
                        res_q <= md_fix(func_q, step_next, neg_q_q, neg_r_q, dz_q, dvd_q);
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs and result select.
    always_comb begin
        stall     = 1'b0;
        out_valid = 1'b0;
        result    = (state == DONE) ? res_q : alu_result;
        if (rst_n && !flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        stall     = ctrl_md_en;
                        out_valid = ~ctrl_md_en;
                    end
                end
                BUSY:    stall     = 1'b1;
                default: out_valid = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed vectors with a scoreboard for ex_stage_md.
module tb_ex_stage_md;

    localparam int unsigned W  = 32;
    localparam int unsigned NF = 2;
`ifdef EX_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    data_rs1, data_rs2, data_pc, data_imm;
    logic [NF*W-1:0] fwd_data;
    logic [1:0]      fwd_a_sel, fwd_b_sel;
    logic [3:0]      ctrl_alu_func;
    logic [1:0]      ctrl_alu_op, ctrl_alu_src_a, ctrl_alu_src_b;
    logic            ctrl_md_en;
    logic [2:0]      md_func;
    logic            flush;
    logic            stall, out_valid;
    logic [W-1:0]    result;

    ex_stage_md #(.DWIDTH(W), .NUM_FWD(NF)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .data_rs1(data_rs1), .data_rs2(data_rs2), .data_pc(data_pc), .data_imm(data_imm),
        .fwd_data(fwd_data), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ctrl_alu_func(ctrl_alu_func), .ctrl_alu_op(ctrl_alu_op),
        .ctrl_alu_src_a(ctrl_alu_src_a), .ctrl_alu_src_b(ctrl_alu_src_b),
        .ctrl_md_en(ctrl_md_en), .md_func(md_func), .flush(flush),
        .stall(stall), .out_valid(out_valid), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every presented result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: result 0x%08h, none expected", result);
            end else begin
                chk(name_q.pop_front(), result, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 0; data_rs1 = '0; data_rs2 = '0; data_pc = '0; data_imm = '0;
        fwd_data = '0; fwd_a_sel = '0; fwd_b_sel = '0; ctrl_alu_func = '0;
        ctrl_alu_op = '0; ctrl_alu_src_a = '0; ctrl_alu_src_b = '0;
        ctrl_md_en = 0; md_func = '0; flush = 0;
    endtask

    // ALU instruction: result expected in the same cycle, no stall.
    task automatic alu_vec(input string name, input logic [1:0] op, input logic [3:0] func,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                           input logic [W-1:0] pc, input logic [W-1:0] imm,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [W-1:0] f0, input logic [W-1:0] f1,
                           input logic [W-1:0] exp);
        exp_q.push_back(exp); name_q.push_back(name);
        in_valid = 1; ctrl_md_en = 0; ctrl_alu_op = op; ctrl_alu_func = func;
        ctrl_alu_src_a = sa; ctrl_alu_src_b = sb; data_rs1 = rs1; data_rs2 = rs2;
        data_pc = pc; data_imm = imm; fwd_a_sel = fa; fwd_b_sel = fb; fwd_data = {f1, f0};
        @(negedge clk);
        chk({name, "_stall"}, W'(stall), '0);
        chk({name, "_valid"}, W'(out_valid), W'(1));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Mul/div instruction: held while stalled; stall length checked here.
    task automatic md_vec(input string name, input logic [2:0] func,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] fb, input logic [W-1:0] f1,
                          input logic [W-1:0] exp);
        int  n;
        bit  done;
        int  exp_n;
        exp_q.push_back(exp); name_q.push_back(name);
        in_valid = 1; ctrl_md_en = 1; md_func = func; data_rs1 = a; data_rs2 = b;
        fwd_b_sel = fb; fwd_data = {f1, W'(0)};
        n = 0; done = 0;
        exp_n = (FAST && !func[2]) ? 1 : int'(W) + 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid) begin done = 1; break; end
            if (stall) n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no out_valid within 200 cycles", name);
        end
        chk({name, "_stall_cycles"}, W'(n), W'(exp_n));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int ov;
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", W'(stall), '0);
        chk("reset_valid", W'(out_valid), '0);
        chk("reset_result", result, '0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // ALU path
        alu_vec("add_fwd_a",   2'b10, 4'b0000, 2'b00, 2'b00, 5, 7, 0, 0, 1, 0, 100, 0, 107);
        alu_vec("sub_fwd_b",   2'b10, 4'b1000, 2'b00, 2'b00, 50, 7, 0, 0, 0, 2, 0, 30, 20);
        alu_vec("add_sel_oor", 2'b10, 4'b0000, 2'b00, 2'b00, 5, 7, 0, 0, 3, 3, 100, 100, 12);
        alu_vec("addi",        2'b11, 4'b1000, 2'b00, 2'b01, 10, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 9);
        alu_vec("pc_plus4",    2'b00, 4'b0000, 2'b01, 2'b10, 0, 0, 32'h1000, 0, 0, 0, 0, 0, 32'h1004);
        alu_vec("lui",         2'b00, 4'b0000, 2'b10, 2'b01, 9, 0, 0, 32'h1234_5000, 0, 0, 0, 0, 32'h1234_5000);
        alu_vec("sra",         2'b10, 4'b1101, 2'b00, 2'b00, 32'h8000_0000, 4, 0, 0, 0, 0, 0, 0, 32'hF800_0000);
        alu_vec("slt",         2'b10, 4'b0010, 2'b00, 2'b00, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 1);
        alu_vec("branch_sub",  2'b01, 4'b0000, 2'b00, 2'b00, 3, 5, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE);

        // Multiply
        md_vec("mul_neg",   3'd0, 32'hFFFF_FFFD, 7, 0, 0, 32'hFFFF_FFEB);
        md_vec("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000);
        md_vec("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE);
        md_vec("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        md_vec("mul_fwd_b", 3'd0, 5, 99, 2, 6, 30);

        // Divide
        md_vec("div_neg",    3'd4, 32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFD);
        md_vec("rem_neg",    3'd6, 32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFF);
        md_vec("div_negdiv", 3'd4, 7, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFD);
        md_vec("rem_negdiv", 3'd6, 7, 32'hFFFF_FFFE, 0, 0, 1);
        md_vec("divu_zero",  3'd5, 5, 0, 0, 0, 32'hFFFF_FFFF);
        md_vec("rem_zero",   3'd6, 5, 0, 0, 0, 5);
        md_vec("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000);
        md_vec("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        md_vec("remu",       3'd7, 100, 7, 0, 0, 2);

        // Flush overrides acceptance in IDLE
        in_valid = 1; ctrl_md_en = 1; md_func = 3'd4; data_rs1 = 100; data_rs2 = 7; flush = 1;
        @(negedge clk);
        chk("flush_idle_stall", W'(stall), '0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("flush_idle_not_busy", W'(stall), '0);
        @(posedge clk); #1;

        // Flush in BUSY cycle 10
        in_valid = 1; ctrl_md_en = 1; md_func = 3'd4; data_rs1 = 100; data_rs2 = 7;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_before_flush", W'(stall), W'(1));
        flush = 1;
        #1;
        chk("flush_busy_stall", W'(stall), '0);
        chk("flush_busy_valid", W'(out_valid), '0);
        @(posedge clk); #1;
        idle_inputs();
        ov = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || stall) ov++;
        end
        chk("flush_no_activity", W'(ov), '0);
        @(posedge clk); #1;
        alu_vec("add_after_flush", 2'b10, 4'b0000, 2'b00, 2'b00, 20, 22, 0, 0, 0, 0, 0, 0, 42);

        // Reset during BUSY
        in_valid = 1; ctrl_md_en = 1; md_func = 3'd5; data_rs1 = 100; data_rs2 = 7;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_busy_stall", W'(stall), '0);
        chk("rst_busy_valid", W'(out_valid), '0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy_result", result, '0);
        @(posedge clk); #1;
        rst_n = 1;
        ov = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || stall) ov++;
        end
        chk("rst_no_activity", W'(ov), '0);
        @(posedge clk); #1;

        // Back-to-back DIVU after reset
        md_vec("divu_b2b_0", 3'd5, 100, 7, 0, 0, 14);
        md_vec("divu_b2b_1", 3'd5, 32'hFFFF_FFFF, 16, 0, 0, 32'h0FFF_FFFF);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
